// File: rtl/secded_decoder_pipe_if.sv
// Codeword-in / corrected-data-out stream bundle for secded_decoder_pipe.
// master = producer/consumer side, slave = decoder side.
interface secded_decoder_pipe_if #(
   parameter int DATA_W = 8
);
   function automatic int calc_par_w(input int d);
      int r;
      r = 0;
      for (int p = 16; p >= 1; p--)
         if ((1 << p) >= d + p + 1) r = p;
      return r;
   endfunction

   localparam int PAR_W = calc_par_w(DATA_W);
   localparam int CW_W  = DATA_W + PAR_W + 1;

   logic              cw_valid_i;
   logic              cw_ready_o;
   logic [CW_W-1:0]   cw_i;
   logic              dat_valid_o;
   logic              dat_ready_i;
   logic [DATA_W-1:0] data_o;
   logic              err_sec_o;
   logic              err_ded_o;
   logic [PAR_W-1:0]  err_pos_o;

   modport master (
      output cw_valid_i, cw_i, dat_ready_i,
      input  cw_ready_o, dat_valid_o, data_o,
      input  err_sec_o, err_ded_o, err_pos_o
   );

   modport slave (
      input  cw_valid_i, cw_i, dat_ready_i,
      output cw_ready_o, dat_valid_o, data_o,
      output err_sec_o, err_ded_o, err_pos_o
   );
endinterface

// File: rtl/secded_decoder_pipe.sv
// Two-stage pipelined extended-Hamming SECDED decoder with valid/ready stream.
// Optional saturating error counters enabled by defining HAM_ERR_CNT_EN.
module secded_decoder_pipe #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   secded_decoder_pipe_if.slave bus,
   input  logic             cnt_clr_i,
   output logic [CNT_W-1:0] sec_cnt_o,
   output logic [CNT_W-1:0] ded_cnt_o
);
   function automatic int calc_par_w(input int d);
      int r;
      r = 0;
      for (int p = 16; p >= 1; p--)
         if ((1 << p) >= d + p + 1) r = p;
      return r;
   endfunction

   localparam int PAR_W = calc_par_w(DATA_W);
   localparam int CW_W  = DATA_W + PAR_W + 1;

   // Payload bits live at the non-power-of-2 positions, ascending.
   function automatic logic [DATA_W-1:0] payload(
      input logic [CW_W-1:0] cw
   );
      logic [DATA_W-1:0] res;
      int k;
      res = '0;
      k = 0;
      for (int j = 1; j < CW_W; j++) begin
         if ((j & (j - 1)) != 0) begin
            res[k] = cw[j-1];
            k++;
         end
      end
      return res;
   endfunction

   logic              s1_vld_q, s1_vld_d;
   logic [CW_W-1:0]   s1_cw_q, s1_cw_d;
   logic [PAR_W-1:0]  s1_syn_q, s1_syn_d;
   logic              s1_ovp_q, s1_ovp_d;

   logic              vld_q, vld_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              sec_q, sec_d;
   logic              ded_q, ded_d;
   logic [PAR_W-1:0]  pos_q, pos_d;

   logic              s1_adv, s2_adv;
   logic              syn_zero, syn_in;
   logic              is_sec, is_ded;
   logic [CW_W-1:0]   fix_cw;

   assign s2_adv = !vld_q || bus.dat_ready_i;
   assign s1_adv = !s1_vld_q || s2_adv;

   assign bus.cw_ready_o  = s1_adv;
   assign bus.dat_valid_o = vld_q;
   assign bus.data_o      = data_q;
   assign bus.err_sec_o   = sec_q;
   assign bus.err_ded_o   = ded_q;
   assign bus.err_pos_o   = pos_q;

   always_comb begin
      s1_vld_d = s1_vld_q;
      s1_cw_d  = s1_cw_q;
      s1_syn_d = s1_syn_q;
      s1_ovp_d = s1_ovp_q;
      if (s1_adv) begin
         s1_vld_d = bus.cw_valid_i;
         if (bus.cw_valid_i) begin
            s1_cw_d  = bus.cw_i;
            s1_syn_d = '0;
            for (int j = 1; j < CW_W; j++)
               if (bus.cw_i[j-1]) s1_syn_d = s1_syn_d ^ PAR_W'(j);
            s1_ovp_d = ^bus.cw_i;
         end
      end
   end

   // Syndromes beyond the last position only arise from >=3 errors.
   assign syn_zero = (s1_syn_q == '0);
   assign syn_in   = (32'(s1_syn_q) < CW_W);
   assign is_sec   = s1_ovp_q && syn_in;
   assign is_ded   = (!s1_ovp_q && !syn_zero) || (s1_ovp_q && !syn_in);

   always_comb begin
      fix_cw = s1_cw_q;
      if (is_sec) begin
         for (int j = 1; j < CW_W; j++)
            if (s1_syn_q == PAR_W'(j)) fix_cw[j-1] = ~s1_cw_q[j-1];
      end
   end

   always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      sec_d  = sec_q;
      ded_d  = ded_q;
      pos_d  = pos_q;
      if (s2_adv) begin
         vld_d = s1_vld_q;
         if (s1_vld_q) begin
            data_d = payload(fix_cw);
            sec_d  = is_sec;
            ded_d  = is_ded;
            pos_d  = is_sec ? s1_syn_q : '0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         s1_vld_q <= 1'b0;
         s1_cw_q  <= '0;
         s1_syn_q <= '0;
         s1_ovp_q <= 1'b0;
         vld_q    <= 1'b0;
         data_q   <= '0;
         sec_q    <= 1'b0;
         ded_q    <= 1'b0;
         pos_q    <= '0;
      end else begin
         s1_vld_q <= s1_vld_d;
         s1_cw_q  <= s1_cw_d;
         s1_syn_q <= s1_syn_d;
         s1_ovp_q <= s1_ovp_d;
         vld_q    <= vld_d;
         data_q   <= data_d;
         sec_q    <= sec_d;
         ded_q    <= ded_d;
         pos_q    <= pos_d;
      end
   end

`ifdef HAM_ERR_CNT_EN
   logic             out_hs;
   logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
   logic [CNT_W-1:0] ded_cnt_q, ded_cnt_d;

   assign out_hs = vld_q && bus.dat_ready_i;

   // Clear takes priority over a same-cycle increment.
   always_comb begin
      sec_cnt_d = sec_cnt_q;
      ded_cnt_d = ded_cnt_q;
      if (cnt_clr_i) begin
         sec_cnt_d = '0;
         ded_cnt_d = '0;
      end else if (out_hs) begin
         if (sec_q && sec_cnt_q != '1)
            sec_cnt_d = sec_cnt_q + CNT_W'(1);
         if (ded_q && ded_cnt_q != '1)
            ded_cnt_d = ded_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sec_cnt_q <= '0;
         ded_cnt_q <= '0;
      end else begin
         sec_cnt_q <= sec_cnt_d;
         ded_cnt_q <= ded_cnt_d;
      end
   end

   assign sec_cnt_o = sec_cnt_q;
   assign ded_cnt_o = ded_cnt_q;
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr_i;
   assign sec_cnt_o = '0;
   assign ded_cnt_o = '0;
`endif
endmodule

// File: tb/tb_secded_decoder_pipe.sv
// Scoreboard bench for secded_decoder_pipe: random codewords with 0-2 injected
// bit errors, backpressure, stalls, mid-stream reset and error counters.
module tb_secded_decoder_pipe;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 4;
   localparam int CW_W   = 13;
`ifdef HAM_ERR_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] data;
      logic       sec;
      logic       ded;
      logic [3:0] pos;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cnt_clr = 1'b0;
   logic [CNT_W-1:0] sec_cnt, ded_cnt;

   always #5 clk = ~clk;

   secded_decoder_pipe_if #(.DATA_W(DATA_W)) bus ();

   secded_decoder_pipe #(
      .DATA_W(DATA_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .bus      (bus),
      .cnt_clr_i(cnt_clr),
      .sec_cnt_o(sec_cnt),
      .ded_cnt_o(ded_cnt)
   );

   int   total = 0;
   int   bad = 0;
   int   rdy_mode = 0;
   logic rdy_manual = 1'b1;
   bit   seen_stall = 1'b0;
   int   exp_sec_cnt = 0;
   int   exp_ded_cnt = 0;
   exp_t sb[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Parity bit at position 2^b holds bit b of the XOR of set data positions.
   function automatic logic [12:0] encode(input logic [7:0] d);
      logic [12:0] cw;
      int k;
      int s;
      cw = '0;
      k = 0;
      s = 0;
      for (int p = 1; p <= 12; p++) begin
         if ((p & (p - 1)) != 0) begin
            cw[p-1] = d[k];
            if (d[k]) s = s ^ p;
            k++;
         end
      end
      for (int b = 0; b < 4; b++) cw[(1 << b) - 1] = s[b];
      cw[12] = ^cw[11:0];
      return cw;
   endfunction

   function automatic logic [7:0] raw(input logic [12:0] cw);
      logic [7:0] d;
      int k;
      d = '0;
      k = 0;
      for (int p = 1; p <= 12; p++) begin
         if ((p & (p - 1)) != 0) begin
            d[k] = cw[p-1];
            k++;
         end
      end
      return d;
   endfunction

   always @(negedge clk) begin
      case (rdy_mode)
         0:       bus.dat_ready_i = 1'b1;
         1:       bus.dat_ready_i = ($urandom_range(0, 3) != 0);
         default: bus.dat_ready_i = rdy_manual;
      endcase
   end

   logic       stalled_q = 1'b0;
   logic [7:0] hd;
   logic [5:0] hflags;
   exp_t       me;

   always @(negedge clk) begin
      #2;
      if (!rst_n) begin
         stalled_q = 1'b0;
         exp_sec_cnt = 0;
         exp_ded_cnt = 0;
      end else begin
         if (stalled_q) begin
            chk("hold_valid", bus.dat_valid_o, 1);
            chk("hold_data", bus.data_o, hd);
            chk("hold_flags",
                {bus.err_sec_o, bus.err_ded_o, bus.err_pos_o}, hflags);
         end
         if (bus.dat_valid_o && bus.dat_ready_i) begin
            chk("sec_cnt", sec_cnt, exp_sec_cnt);
            chk("ded_cnt", ded_cnt, exp_ded_cnt);
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_output: got data %0h want none",
                        bus.data_o);
            end else begin
               me = sb.pop_front();
               chk("data", bus.data_o, me.data);
               chk("err_sec", bus.err_sec_o, me.sec);
               chk("err_ded", bus.err_ded_o, me.ded);
               chk("err_pos", bus.err_pos_o, me.pos);
               if (CNT_EN && me.sec && exp_sec_cnt < 15) exp_sec_cnt++;
               if (CNT_EN && me.ded && exp_ded_cnt < 15) exp_ded_cnt++;
            end
         end
         if (cnt_clr) begin
            exp_sec_cnt = 0;
            exp_ded_cnt = 0;
         end
         stalled_q = bus.dat_valid_o && !bus.dat_ready_i;
         hd = bus.data_o;
         hflags = {bus.err_sec_o, bus.err_ded_o, bus.err_pos_o};
      end
   end

   task automatic send(input logic [12:0] cw, input exp_t e);
      int n;
      @(negedge clk);
      bus.cw_valid_i = 1'b1;
      bus.cw_i = cw;
      #1;
      n = 0;
      while (!bus.cw_ready_o && n < 200) begin
         seen_stall = 1'b1;
         @(negedge clk);
         #1;
         n++;
      end
      if (!bus.cw_ready_o) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got ready 0 want 1");
      end else begin
         sb.push_back(e);
      end
   endtask

   task automatic send_d(input logic [12:0] cw, input logic [7:0] d,
                         input logic s, input logic dd,
                         input logic [3:0] p);
      exp_t e;
      e.data = d;
      e.sec = s;
      e.ded = dd;
      e.pos = p;
      send(cw, e);
   endtask

   task automatic send_rand(input int nmin, input int nmax);
      logic [7:0]  d;
      logic [12:0] cw;
      int n, b1, b2;
      exp_t e;
      d = 8'($urandom);
      cw = encode(d);
      n = $urandom_range(nmin, nmax);
      b1 = $urandom_range(0, 12);
      b2 = $urandom_range(0, 11);
      if (b2 >= b1) b2++;
      e.data = d;
      e.sec = 1'b0;
      e.ded = 1'b0;
      e.pos = 4'd0;
      if (n >= 1) cw[b1] = ~cw[b1];
      if (n == 1) begin
         e.sec = 1'b1;
         e.pos = (b1 == 12) ? 4'd0 : 4'(b1 + 1);
      end
      if (n == 2) begin
         cw[b2] = ~cw[b2];
         e.ded = 1'b1;
         e.data = raw(cw);
      end
      send(cw, e);
   endtask

   task automatic idle();
      @(negedge clk);
      bus.cw_valid_i = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk(name, sb.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cw_valid_i = 1'b0;
      bus.cw_i = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #2;
      chk("rst_valid", bus.dat_valid_o, 0);
      chk("rst_data", bus.data_o, 0);
      chk("rst_flags", {bus.err_sec_o, bus.err_ded_o, bus.err_pos_o}, 0);
      chk("rst_cnt", {sec_cnt, ded_cnt}, 0);
      chk("rst_ready", bus.cw_ready_o, 1);

      rdy_mode = 0;
      send_d(13'h0A27, 8'hA5, 1'b0, 1'b0, 4'd0);
      send_d(13'h0A07, 8'hA5, 1'b1, 1'b0, 4'd6);
      send_d(13'h1A27, 8'hA5, 1'b1, 1'b0, 4'd0);
      send_d(13'h0826, 8'h85, 1'b0, 1'b1, 4'd0);
      send_d(13'h0AAE, 8'hA5, 1'b0, 1'b1, 4'd0);
      idle();
      drain("directed_drain");

      rdy_mode = 1;
      repeat (200) send_rand(0, 2);
      idle();
      drain("random_drain");

      rdy_mode = 2;
      rdy_manual = 1'b1;
      seen_stall = 1'b0;
      fork
         repeat (8) send_rand(0, 2);
         begin
            repeat (3) @(negedge clk);
            rdy_manual = 1'b0;
            repeat (4) @(negedge clk);
            rdy_manual = 1'b1;
         end
      join
      idle();
      drain("stall_drain");
      chk("stall_backpressure", seen_stall, 1);

      rdy_mode = 0;
      repeat (20) send_rand(1, 1);
      idle();
      drain("sat_drain");
      chk("sec_cnt_sat", sec_cnt, exp_sec_cnt);

      fork
         repeat (6) send_rand(1, 1);
         begin
            repeat (4) @(negedge clk);
            cnt_clr = 1'b1;
            @(negedge clk);
            cnt_clr = 1'b0;
         end
      join
      idle();
      drain("clr_drain");
      chk("sec_cnt_after_clr", sec_cnt, exp_sec_cnt);
      chk("ded_cnt_after_clr", ded_cnt, exp_ded_cnt);

      rdy_mode = 2;
      rdy_manual = 1'b0;
      send_rand(0, 2);
      send_rand(0, 2);
      @(negedge clk);
      bus.cw_valid_i = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      chk("midrst_valid", bus.dat_valid_o, 0);
      chk("midrst_cnt", {sec_cnt, ded_cnt}, 0);
      chk("midrst_ready", bus.cw_ready_o, 1);
      sb.delete();
      rdy_manual = 1'b1;
      repeat (6) @(negedge clk);
      #2;
      chk("midrst_no_output", bus.dat_valid_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
